softmax_pv_mac: RTL and testbench



---
 rtl/mha_pkg.sv | 12 +
 rtl/pv_mac_lane.sv | 47 ++++
 rtl/softmax_pv_mac.sv | 99 +++++++++
 tb/tb_softmax_pv_mac.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mha_pkg.sv
// mha_pkg: shared FSM states, fixed-point constants and output saturation for the MHA datapath
package mha_pkg;
    typedef enum logic [1:0] {S_IDLE, S_SCALE, S_MAC, S_OUT} state_t;
    localparam int FRAC_W     = 8;
    localparam int ROUND_HALF = 128;
    localparam int SCALE_ONE  = 256;
    localparam int SAT_MAX    = 127;
    localparam int SAT_MIN    = -128;
    function automatic logic [7:0] sat_dw(input logic signed [31:0] x);
        return x > SAT_MAX ? 8'(SAT_MAX) : x < SAT_MIN ? 8'(SAT_MIN) : x[7:0];
    endfunction
endpackage

// File: rtl/pv_mac_lane.sv
// pv_mac_lane: one output column -- accumulator with rescale, P*V MAC, round and saturate
module pv_mac_lane
    import mha_pkg::*;
#(
    parameter int D_W   = 8,
    parameter int ACC_W = 24
) (
    input  logic           I_CLK,
    input  logic           I_RST_N,
    input  logic           clr,
    input  logic           scale_en,
    input  logic           mac_en,
    input  logic           out_en,
    input  logic [D_W:0]   scale,
    input  logic [D_W-1:0] p,
    input  logic [D_W-1:0] v,
    output logic [D_W-1:0] data
);
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W+9:0]  prod_s;
    logic signed [ACC_W+9:0]  resc;
    logic signed [2*D_W:0]    prod_m;
    logic signed [ACC_W:0]    rnd;

    assign prod_s = acc * $signed({1'b0, scale});
    assign resc   = (prod_s + (ACC_W+10)'(ROUND_HALF)) >>> FRAC_W;
    assign prod_m = $signed({1'b0, p}) * $signed(v);
    assign rnd    = ($signed({acc[ACC_W-1], acc}) + (ACC_W+1)'(ROUND_HALF)) >>> FRAC_W;

    // clear or rescale at tile start, then accumulate one P*V product per accepted row
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N)
            acc <= '0;
        else if (scale_en)
            acc <= clr ? '0 : resc[ACC_W-1:0];
        else if (mac_en)
            acc <= acc + ACC_W'(prod_m);
    end

    // round the Q.8 accumulator to integer and saturate into the output byte
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N)
            data <= '0;
        else if (out_en)
            data <= sat_dw(32'(rnd));
    end
endmodule

// File: rtl/softmax_pv_mac.sv
// softmax_pv_mac: streaming softmax-probability x value-row accumulator with online rescale
module softmax_pv_mac
    import mha_pkg::*;
#(
    parameter int D_W   = 8,
    parameter int NUM   = 16,
    parameter int ACC_W = 24
) (
    input  logic           I_CLK,
    input  logic           I_RST_N,
    input  logic           I_P_VLD,
    output logic           O_P_RDY,
    input  logic [D_W-1:0] I_P [0:NUM-1],
    input  logic           I_TILE_FIRST,
    input  logic [D_W:0]   I_SCALE,
    input  logic           I_V_VLD,
    output logic           O_V_RDY,
    input  logic [D_W-1:0] I_V_ROW [0:NUM-1],
    output logic           O_VLD,
    output logic [D_W-1:0] O_DATA [0:NUM-1]
);
    localparam int K_W = $clog2(NUM);

    state_t         state, state_nxt;
    logic [K_W-1:0] k;
    logic [D_W-1:0] p_q [0:NUM-1];
    logic [D_W-1:0] p_sel;
    logic [D_W:0]   scale_q;
    logic           first_q;
    logic           scale_en, mac_en, out_en, last_row;

    assign p_sel    = p_q[k];
    assign last_row = mac_en && k == K_W'(NUM-1);

    // state register
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // next-state: tile accept, one rescale cycle, NUM rows, one output cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = I_P_VLD ? S_SCALE : S_IDLE;
            S_SCALE: state_nxt = S_MAC;
            S_MAC:   state_nxt = last_row ? S_OUT : S_MAC;
            default: state_nxt = S_IDLE;
        endcase
    end

    // handshakes and lane strobes decoded from state
    always_comb begin
        O_P_RDY  = state == S_IDLE;
        O_V_RDY  = state == S_MAC;
        scale_en = state == S_SCALE;
        out_en   = state == S_OUT;
        mac_en   = O_V_RDY && I_V_VLD;
    end

    // tile capture (scale clamped to 1.0), row counter and output strobe
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            p_q     <= '{default: '0};
            scale_q <= '0;
            first_q <= 1'b0;
            k       <= '0;
            O_VLD   <= 1'b0;
        end else begin
            if (O_P_RDY && I_P_VLD) begin
                p_q     <= I_P;
                scale_q <= I_SCALE > (D_W+1)'(SCALE_ONE) ? (D_W+1)'(SCALE_ONE) : I_SCALE;
                first_q <= I_TILE_FIRST;
            end
            if (scale_en)
                k <= '0;
            else if (mac_en)
                k <= k + 1'b1;
            O_VLD <= out_en;
        end
    end

    for (genvar i = 0; i < NUM; i++) begin : g_lane
        pv_mac_lane #(.D_W(D_W), .ACC_W(ACC_W)) u_lane (
            .I_CLK    (I_CLK),
            .I_RST_N  (I_RST_N),
            .clr      (first_q),
            .scale_en (scale_en),
            .mac_en   (mac_en),
            .out_en   (out_en),
            .scale    (scale_q),
            .p        (p_sel),
            .v        (I_V_ROW[i]),
            .data     (O_DATA[i])
        );
    end
endmodule

// File: tb/tb_softmax_pv_mac.sv
// tb_softmax_pv_mac: directed and random tiles checked against an arithmetic reference model
module tb_softmax_pv_mac;
    logic       I_CLK = 1'b0;
    logic       I_RST_N = 1'b0;
    logic       I_P_VLD = 1'b0;
    logic       O_P_RDY;
    logic [7:0] I_P [0:15];
    logic       I_TILE_FIRST = 1'b0;
    logic [8:0] I_SCALE = '0;
    logic       I_V_VLD = 1'b0;
    logic       O_V_RDY;
    logic [7:0] I_V_ROW [0:15];
    logic       O_VLD;
    logic [7:0] O_DATA [0:15];

    int     errors = 0;
    int     checks = 0;
    int     cyc = 0;
    int     tp [16];
    int     tv [16][16];
    longint macc [16];
    logic [7:0] exp_o [16];

    softmax_pv_mac #(.D_W(8), .NUM(16), .ACC_W(24)) dut (
        .I_CLK        (I_CLK),
        .I_RST_N      (I_RST_N),
        .I_P_VLD      (I_P_VLD),
        .O_P_RDY      (O_P_RDY),
        .I_P          (I_P),
        .I_TILE_FIRST (I_TILE_FIRST),
        .I_SCALE      (I_SCALE),
        .I_V_VLD      (I_V_VLD),
        .O_V_RDY      (O_V_RDY),
        .I_V_ROW      (I_V_ROW),
        .O_VLD        (O_VLD),
        .O_DATA       (O_DATA)
    );

    always #5 I_CLK = ~I_CLK;
    always @(posedge I_CLK) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int sat(input longint x);
        return x > 127 ? 127 : x < -128 ? -128 : int'(x);
    endfunction

    // reference: rescale or clear, sum P*V over all rows, round half up and saturate
    task automatic model_tile(input bit first, input int scale);
        int s;
        s = scale > 256 ? 256 : scale;
        for (int j = 0; j < 16; j++) begin
            macc[j] = first ? 0 : (macc[j] * s + 128) >>> 8;
            for (int r = 0; r < 16; r++) macc[j] += longint'(tp[r]) * tv[r][j];
            exp_o[j] = 8'(sat((macc[j] + 128) >>> 8));
        end
    endtask

    task automatic fill(input int pv, input int vv);
        for (int r = 0; r < 16; r++) begin
            tp[r] = pv;
            for (int j = 0; j < 16; j++) tv[r][j] = vv;
        end
    endtask

    task automatic check_out(input string tag);
        for (int j = 0; j < 16; j++) check($sformatf("%s_col%0d", tag, j), 32'(O_DATA[j]), 32'(exp_o[j]));
    endtask

    task automatic accept(input bit first, input int scale, output int t);
        I_P_VLD = 1'b1;
        I_TILE_FIRST = first;
        I_SCALE = 9'(scale);
        for (int j = 0; j < 16; j++) I_P[j] = 8'(tp[j]);
        @(posedge I_CLK); #1;
        t = cyc;
        I_P_VLD = 1'b0;
        I_TILE_FIRST = 1'b0;
        for (int j = 0; j < 16; j++) I_P[j] = 8'($urandom);
        @(posedge I_CLK); #1;
    endtask

    task automatic send_row(input int r);
        I_V_VLD = 1'b1;
        for (int j = 0; j < 16; j++) I_V_ROW[j] = 8'(tv[r][j]);
        @(posedge I_CLK); #1;
        I_V_VLD = 1'b0;
        for (int j = 0; j < 16; j++) I_V_ROW[j] = 8'($urandom);
    endtask

    task automatic run_tile(input string tag, input bit first, input int scale, input bit gap, input bit inject);
        int t, n;
        check({tag, "_prdy_idle"}, 32'(O_P_RDY), 1);
        accept(first, scale, t);
        check({tag, "_prdy_busy"}, 32'(O_P_RDY), 0);
        for (int r = 0; r < 16; r++) begin
            if (gap && r > 0) begin
                @(posedge I_CLK); #1;
            end
            if (r == 0) check({tag, "_vrdy"}, 32'(O_V_RDY), 1);
            if (inject && r == 5) begin
                I_P_VLD = 1'b1;
                I_TILE_FIRST = 1'b1;
                I_SCALE = 9'd0;
                for (int j = 0; j < 16; j++) I_P[j] = 8'd200;
            end
            send_row(r);
            I_P_VLD = 1'b0;
            I_TILE_FIRST = 1'b0;
        end
        model_tile(first, scale);
        n = 0;
        while (!O_VLD && n < 40) begin
            @(posedge I_CLK); #1;
            n++;
        end
        check({tag, "_ovld"}, 32'(O_VLD), 1);
        check({tag, "_latency"}, 32'(cyc - t), gap ? 33 : 18);
        check_out(tag);
        @(posedge I_CLK); #1;
        check({tag, "_ovld_pulse"}, 32'(O_VLD), 0);
        check({tag, "_prdy_back"}, 32'(O_P_RDY), 1);
    endtask

    initial begin
        int t, seen;
        for (int j = 0; j < 16; j++) begin
            I_P[j] = '0;
            I_V_ROW[j] = '0;
            macc[j] = 0;
            exp_o[j] = '0;
        end
        repeat (2) @(posedge I_CLK);
        #1;
        check("rst_ovld", 32'(O_VLD), 0);
        check("rst_prdy", 32'(O_P_RDY), 1);
        check("rst_vrdy", 32'(O_V_RDY), 0);
        check_out("rst_data");
        I_RST_N = 1'b1;
        @(posedge I_CLK); #1;
        check("rst_rel_prdy", 32'(O_P_RDY), 1);

        fill(16, 64);
        run_tile("fresh", 1'b1, 0, 1'b0, 1'b0);
        fill(0, 0);
        run_tile("scale128", 1'b0, 128, 1'b0, 1'b0);
        run_tile("scale256", 1'b0, 256, 1'b0, 1'b0);
        run_tile("scale511", 1'b0, 511, 1'b0, 1'b0);

        fill(0, 0);
        tp[0] = 255;
        for (int r = 1; r < 16; r++)
            for (int j = 0; j < 16; j++) tv[r][j] = int'($urandom_range(0, 255)) - 128;
        tv[0][0] = -128;
        tv[0][1] = 100;
        run_tile("select", 1'b1, 0, 1'b0, 1'b0);

        fill(255, 127);
        run_tile("sat_pos", 1'b1, 0, 1'b0, 1'b0);
        fill(255, -128);
        run_tile("sat_neg", 1'b1, 0, 1'b0, 1'b0);

        fill(16, 64);
        run_tile("backpr", 1'b1, 0, 1'b1, 1'b1);

        for (int n = 0; n < 6; n++) begin
            for (int r = 0; r < 16; r++) begin
                tp[r] = int'($urandom_range(0, 40));
                for (int j = 0; j < 16; j++) tv[r][j] = int'($urandom_range(0, 255)) - 128;
            end
            run_tile($sformatf("rand%0d", n), n == 0 ? 1'b1 : 1'($urandom), int'($urandom_range(0, 511)), 1'($urandom), 1'b0);
        end

        fill(16, 64);
        accept(1'b1, 0, t);
        for (int r = 0; r < 8; r++) send_row(r);
        I_RST_N = 1'b0;
        #2;
        for (int j = 0; j < 16; j++) begin
            macc[j] = 0;
            exp_o[j] = '0;
        end
        check("midrst_ovld", 32'(O_VLD), 0);
        check("midrst_prdy", 32'(O_P_RDY), 1);
        check("midrst_vrdy", 32'(O_V_RDY), 0);
        repeat (2) @(posedge I_CLK);
        #1;
        I_RST_N = 1'b1;
        seen = 0;
        for (int r = 8; r < 16; r++) begin
            I_V_VLD = 1'b1;
            @(posedge I_CLK); #1;
            seen |= int'(O_VLD);
        end
        I_V_VLD = 1'b0;
        repeat (12) begin
            @(posedge I_CLK); #1;
            seen |= int'(O_VLD);
        end
        check("midrst_no_ovld", 32'(seen), 0);
        check("midrst_prdy_rel", 32'(O_P_RDY), 1);
        check_out("midrst_data");
        run_tile("post_rst", 1'b0, 256, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
